// File: rtl/response_encoder.sv
// response_encoder: serialises a coprocessor result as the ASCII line
// "<cmd char>=<hex digits>\n" into a byte-wide UART transmitter using a
// start/busy handshake. One byte is offered per SEND visit. A GUARD cycle
// follows each tx_start because the UART may raise tx_busy a cycle late.
module response_encoder #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result,
    input  logic [2:0]        cmd,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              busy,
    output logic              done
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = $clog2(NIB + 3);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [2:0]        cmd_q, cmd_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Map one nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) begin
            c = 8'h30 + {4'd0, n};
        end else begin
            c = 8'h37 + {4'd0, n};
        end
        return c;
    endfunction

    // Byte at position idx of the frame for the latched command and result.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0]  idx,
                                              input logic [2:0]        c,
                                              input logic [DATA_W-1:0] r);
        logic [7:0] b;
        int         k;
        k = 0;
        if (idx == {IDX_W{1'b0}}) begin
            case (c)
                3'd1:    b = 8'h61;
                3'd2:    b = 8'h62;
                default: b = 8'h3F;
            endcase
        end else if (idx == IDX_W'(1)) begin
            b = 8'h3D;
        end else if (idx == LAST_IDX) begin
            b = 8'h0A;
        end else begin
            // Digit positions 2..NIB+1 walk from the top nibble down.
            k = NIB + 1 - int'(idx);
            b = hex_char(r[4*k +: 4]);
        end
        return b;
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= {IDX_W{1'b0}};
            result_q   <= {DATA_W{1'b0}};
            cmd_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            result_q   <= result_d;
            cmd_q      <= cmd_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (result_valid) begin
                    state_d = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    state_d = GUARD;
                end else begin
                    state_d = SEND;
                end
            end
            GUARD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (idx_q < LAST_IDX) begin
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, byte index and latched request.
    always_comb begin
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        result_d   = result_q;
        cmd_d      = cmd_q;
        case (state_q)
            IDLE: begin
                if (result_valid) begin
                    busy_d   = 1'b1;
                    idx_d    = {IDX_W{1'b0}};
                    result_d = result;
                    cmd_d    = cmd;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = frame_byte(idx_q, cmd_q, result_q);
                end else begin
                    tx_start_d = 1'b0;
                end
            end
            GUARD: begin
                tx_start_d = 1'b0;
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        idx_d  = {IDX_W{1'b0}};
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
                idx_d  = {IDX_W{1'b0}};
            end
        endcase
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
